// File: rtl/fetcher_if.sv
// Fetch-stage bus: back-pressure and redirect from the ROB side, instruction-memory
// request/response, and the issue port toward decode.
interface fetcher_if;
    logic        in_rob_full;
    logic        in_rs_full;
    logic        in_slb_full;
    logic        in_rob_misbranch;
    logic [31:0] in_rob_newpc;
    logic        out_mem_ce;
    logic [31:0] out_mem_pc;
    logic        in_mem_ce;
    logic [31:0] in_mem_instr;
    logic [31:0] out_decode_instr;
    logic [31:0] out_decode_pc;
    logic        out_decode_jump_ce;
    logic        out_issue_valid;

    modport master (
        input  in_rob_full, in_rs_full, in_slb_full, in_rob_misbranch, in_rob_newpc,
        input  in_mem_ce, in_mem_instr,
        output out_mem_ce, out_mem_pc,
        output out_decode_instr, out_decode_pc, out_decode_jump_ce, out_issue_valid
    );

    modport slave (
        output in_rob_full, in_rs_full, in_slb_full, in_rob_misbranch, in_rob_newpc,
        output in_mem_ce, in_mem_instr,
        input  out_mem_ce, out_mem_pc,
        input  out_decode_instr, out_decode_pc, out_decode_jump_ce, out_issue_valid
    );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch: direct-mapped one-word-line I-cache, miss handling toward memory,
// static branch prediction (JAL and backward branches taken) and ROB redirects.
module fetcher #(
    parameter int          ICACHE_INDEX_BITS = 5,
    parameter logic [31:0] RESET_PC          = 32'h0
) (
    input logic       clk,
    input logic       rst,
    input logic       rdy,
    fetcher_if.master bus
);
    localparam int LINES = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_W = 32 - ICACHE_INDEX_BITS - 2;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_q, pc_d;
    logic [LINES-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]       tag_mem [LINES];
    logic [31:0]            data_mem [LINES];

    logic                   mem_ce_q, mem_ce_d;
    logic [31:0]            mem_pc_q, mem_pc_d;
    logic [31:0]            dec_instr_q, dec_instr_d;
    logic [31:0]            dec_pc_q, dec_pc_d;
    logic                   jump_q, jump_d;
    logic                   issue_q, issue_d;

    logic [ICACHE_INDEX_BITS-1:0] idx, fill_idx;
    logic                   hit, stall, fill_en, take;
    logic [31:0]            word, pred_pc;
    logic signed [31:0]     imm_j, imm_b;

    always_comb begin
        idx      = pc_q[ICACHE_INDEX_BITS+1:2];
        fill_idx = mem_pc_q[ICACHE_INDEX_BITS+1:2];
        word     = data_mem[idx];
        hit      = valid_q[idx] && (tag_mem[idx] == pc_q[31:ICACHE_INDEX_BITS+2]);
        stall    = bus.in_rob_full | bus.in_rs_full | bus.in_slb_full;
        // A fill is only accepted while a request is actually outstanding.
        fill_en  = (state_q == WAIT_MEM) && bus.in_mem_ce;

        imm_j = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
        imm_b = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
        take    = 1'b0;
        pred_pc = pc_q + 32'd4;
        if (word[6:0] == 7'b1101111) begin
            take    = 1'b1;
            pred_pc = pc_q + $unsigned(imm_j);
        end else if (word[6:0] == 7'b1100011 && word[31]) begin
            take    = 1'b1;
            pred_pc = pc_q + $unsigned(imm_b);
        end

        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        mem_ce_d    = mem_ce_q;
        mem_pc_d    = mem_pc_q;
        dec_instr_d = 32'h0;
        dec_pc_d    = dec_pc_q;
        jump_d      = 1'b0;
        issue_d     = 1'b0;

        if (fill_en) valid_d[fill_idx] = 1'b1;

        if (bus.in_rob_misbranch) begin
            pc_d     = bus.in_rob_newpc;
            state_d  = IDLE;
            mem_ce_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        if (hit) begin
                            issue_d     = 1'b1;
                            dec_instr_d = word;
                            dec_pc_d    = pc_q;
                            jump_d      = take;
                            pc_d        = pred_pc;
                        end else begin
                            mem_ce_d = 1'b1;
                            mem_pc_d = pc_q;
                            state_d  = WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.in_mem_ce) begin
                        mem_ce_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            valid_q     <= '0;
            mem_ce_q    <= 1'b0;
            mem_pc_q    <= 32'h0;
            dec_instr_q <= 32'h0;
            dec_pc_q    <= 32'h0;
            jump_q      <= 1'b0;
            issue_q     <= 1'b0;
        end else if (rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            mem_ce_q    <= mem_ce_d;
            mem_pc_q    <= mem_pc_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            jump_q      <= jump_d;
            issue_q     <= issue_d;
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            tag_mem[fill_idx]  <= mem_pc_q[31:ICACHE_INDEX_BITS+2];
            data_mem[fill_idx] <= bus.in_mem_instr;
        end
    end

    assign bus.out_mem_ce         = mem_ce_q;
    assign bus.out_mem_pc         = mem_pc_q;
    assign bus.out_decode_instr   = dec_instr_q;
    assign bus.out_decode_pc      = dec_pc_q;
    assign bus.out_decode_jump_ce = jump_q;
    assign bus.out_issue_valid    = issue_q;
endmodule

// File: tb/tb_fetcher.sv
// Bench for fetcher: directed program scenarios followed by randomized traffic, all checked
// against a transaction-level model (cache as address map, memory as generated program).
module tb_fetcher;
    logic clk = 1'b0;
    logic rst, rdy;
    always #5 clk = ~clk;

    fetcher_if bus();
    fetcher dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Directed memory contents with their architecturally expected successor.
    logic [31:0] d_word [logic [31:0]];
    logic [31:0] d_next [logic [31:0]];
    bit          d_jump [logic [31:0]];

    // Model state.
    logic [31:0] m_pc, m_req;
    bit          m_wait;
    logic [31:0] m_line [int];
    logic [31:0] e_mem_pc, e_instr, e_pc;
    bit          e_mem_ce, e_valid, e_jump;
    int          lat_cnt = 0, max_lat = 0;
    bit          mem_quiet = 0, force_ce = 0;
    logic [31:0] force_instr = 32'h0;

    logic [31:0] lg_pc [$];
    logic [31:0] lg_in [$];
    bit          lg_j [$];
    int          lg_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_j(input logic [31:0] o);
        return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] o);
        return {o[12], o[10:5], 5'd0, 5'd0, 3'b000, o[4:1], o[11], 7'b1100011};
    endfunction

    // Memory image: directed words where defined, otherwise a hash-chosen instruction.
    function automatic void fetch_ref(input logic [31:0] a, output logic [31:0] w,
                                      output logic [31:0] nxt, output bit j);
        logic [31:0] h;
        logic [4:0]  s;
        logic [31:0] o;
        if (d_word.exists(a)) begin
            w = d_word[a]; nxt = d_next[a]; j = d_jump[a];
            return;
        end
        h = (a >> 2) * 32'h9E3779B1;
        s = h[31:27];
        o = 32'd4 * ({29'd0, s[2:0]} + 32'd1);
        case (s % 6)
            0: begin w = 32'h00000093 | ({27'd0, s} << 20); nxt = a + 32'd4; j = 0; end
            1: begin w = enc_j(o);       nxt = a + o;     j = 1; end
            2: begin w = enc_j(-o);      nxt = a - o;     j = 1; end
            3: begin w = enc_b(-o);      nxt = a - o;     j = 1; end
            4: begin w = enc_b(o);       nxt = a + 32'd4; j = 0; end
            default: begin w = 32'h000080E7; nxt = a + 32'd4; j = 0; end
        endcase
    endfunction

    function automatic int lidx(input logic [31:0] a);
        return int'(a[6:2]);
    endfunction

    task automatic model_step();
        logic [31:0] w, nxt;
        bit j, fill, stall;
        if (rst) begin
            m_pc = 32'h0; m_wait = 0; m_line.delete();
            e_mem_ce = 0; e_mem_pc = 0; e_valid = 0; e_instr = 0; e_pc = 0; e_jump = 0;
        end else if (rdy) begin
            fill  = m_wait && bus.in_mem_ce;
            stall = bus.in_rob_full || bus.in_rs_full || bus.in_slb_full;
            if (fill) m_line[lidx(m_req)] = m_req;
            e_valid = 0; e_instr = 0; e_jump = 0;
            if (bus.in_rob_misbranch) begin
                m_pc = bus.in_rob_newpc; m_wait = 0; e_mem_ce = 0;
            end else if (m_wait) begin
                if (fill) begin m_wait = 0; e_mem_ce = 0; end
            end else if (!stall) begin
                if (m_line.exists(lidx(m_pc)) && m_line[lidx(m_pc)] == m_pc) begin
                    fetch_ref(m_pc, w, nxt, j);
                    e_valid = 1; e_instr = w; e_pc = m_pc; e_jump = j;
                    m_pc = nxt;
                end else begin
                    e_mem_ce = 1; e_mem_pc = m_pc; m_req = m_pc; m_wait = 1;
                    lat_cnt = $urandom_range(0, max_lat);
                end
            end
        end
    endtask

    task automatic cycle();
        logic [31:0] w, nxt;
        bit j;
        if (m_wait && rdy && !rst && !mem_quiet && lat_cnt == 0) begin
            fetch_ref(m_req, w, nxt, j);
            bus.in_mem_ce = 1'b1; bus.in_mem_instr = w;
        end else begin
            bus.in_mem_ce = force_ce;
            bus.in_mem_instr = force_ce ? force_instr : $urandom;
        end
        @(posedge clk);
        cyc++;
        if (m_wait && rdy && !rst && lat_cnt > 0) lat_cnt--;
        model_step();
        #1;
        chk("issue_valid", {31'd0, bus.out_issue_valid}, {31'd0, e_valid});
        chk("dec_instr", bus.out_decode_instr, e_instr);
        chk("mem_ce", {31'd0, bus.out_mem_ce}, {31'd0, e_mem_ce});
        if (e_valid) begin
            chk("dec_pc", bus.out_decode_pc, e_pc);
            chk("dec_jump", {31'd0, bus.out_decode_jump_ce}, {31'd0, e_jump});
        end
        if (e_mem_ce) chk("mem_pc", bus.out_mem_pc, e_mem_pc);
        if (bus.out_issue_valid) begin
            lg_pc.push_back(bus.out_decode_pc);
            lg_in.push_back(bus.out_decode_instr);
            lg_j.push_back(bus.out_decode_jump_ce);
            lg_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        lg_pc.delete(); lg_in.delete(); lg_j.delete(); lg_cyc.delete();
    endtask

    task automatic run_issues(input int n, input int budget);
        int k = 0;
        while (lg_pc.size() < n && k < budget) begin
            cycle();
            k++;
        end
        if (lg_pc.size() < n) chk("issue_timeout", lg_pc.size(), n);
    endtask

    task automatic redirect(input logic [31:0] npc);
        bus.in_rob_misbranch = 1'b1; bus.in_rob_newpc = npc;
        cycle();
        chk("redir_noissue", {31'd0, bus.out_issue_valid}, 32'd0);
        bus.in_rob_misbranch = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] nxt, input bit j);
        d_word[a] = w; d_next[a] = nxt; d_jump[a] = j;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        put(32'h0,        32'h00500093, 32'h4,   0);
        put(32'h4,        32'h00200113, 32'h8,   0);
        put(32'h8,        32'hFE000CE3, 32'h0,   1);
        put(32'h10,       32'h0100006F, 32'h20,  1);
        put(32'h20,       32'h00000463, 32'h24,  0);
        put(32'h24,       32'h00100013, 32'h28,  0);
        put(32'h40,       32'h04000013, 32'h44,  0);
        put(32'h100,      32'h00000013, 32'h104, 0);
        put(32'hFFFFFFFC, 32'h0080006F, 32'h4,   1);

        rst = 1'b1; rdy = 1'b0;
        bus.in_rob_full = 0; bus.in_rs_full = 0; bus.in_slb_full = 0;
        bus.in_rob_misbranch = 0; bus.in_rob_newpc = 0;
        bus.in_mem_ce = 0; bus.in_mem_instr = 0;
        m_wait = 0; m_pc = 0; m_req = 0;
        repeat (2) cycle();
        chk("rst_issue", {31'd0, bus.out_issue_valid}, 32'd0);
        chk("rst_mem_ce", {31'd0, bus.out_mem_ce}, 32'd0);
        chk("rst_mem_pc", bus.out_mem_pc, 32'd0);
        chk("rst_dec_pc", bus.out_decode_pc, 32'd0);
        chk("rst_jump", {31'd0, bus.out_decode_jump_ce}, 32'd0);

        // Cold start: first request, then the 0/4/8 loop closing on a backward beq.
        rst = 1'b0; rdy = 1'b1;
        cycle();
        chk("cold_req_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        chk("cold_req_pc", bus.out_mem_pc, 32'd0);
        clear_log();
        run_issues(6, 60);
        if (lg_pc.size() >= 6) begin
            chk("cold_instr", lg_in[0], 32'h00500093);
            for (int i = 0; i < 6; i++) begin
                chk("loop_pc", lg_pc[i], (i % 3) * 4);
                chk("loop_jump", {31'd0, lg_j[i]}, (i % 3 == 2) ? 32'd1 : 32'd0);
            end
            chk("loop_b2b_a", lg_cyc[4] - lg_cyc[3], 32'd1);
            chk("loop_b2b_b", lg_cyc[5] - lg_cyc[4], 32'd1);
        end

        bus.in_rob_full = 1'b1;
        repeat (3) begin
            cycle();
            chk("stall_noissue", {31'd0, bus.out_issue_valid}, 32'd0);
        end
        bus.in_rob_full = 1'b0;
        cycle();
        chk("resume_valid", {31'd0, bus.out_issue_valid}, 32'd1);
        chk("resume_pc", bus.out_decode_pc, 32'd0);

        // JAL at 0x10, then forward beq at 0x20 not taken.
        redirect(32'h10);
        clear_log();
        run_issues(3, 60);
        if (lg_pc.size() >= 3) begin
            chk("jal_pc", lg_pc[0], 32'h10);   chk("jal_jump", {31'd0, lg_j[0]}, 32'd1);
            chk("jal_tgt", lg_pc[1], 32'h20);  chk("fwd_jump", {31'd0, lg_j[1]}, 32'd0);
            chk("fwd_next", lg_pc[2], 32'h24);
        end

        // Redirect while a request for 0x40 is outstanding; its late response is dropped.
        mem_quiet = 1;
        redirect(32'h40);
        cycle();
        chk("req40_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        chk("req40_pc", bus.out_mem_pc, 32'h40);
        repeat (2) begin
            cycle();
            chk("req40_hold", bus.out_mem_pc, 32'h40);
        end
        redirect(32'h100);
        chk("redir_ce_drop", {31'd0, bus.out_mem_ce}, 32'd0);
        force_ce = 1; force_instr = 32'h04000013;
        cycle();
        force_ce = 0;
        chk("late_noissue", {31'd0, bus.out_issue_valid}, 32'd0);
        chk("req100_ce", {31'd0, bus.out_mem_ce}, 32'd1);
        chk("req100_pc", bus.out_mem_pc, 32'h100);
        mem_quiet = 0;
        clear_log();
        run_issues(1, 20);
        if (lg_pc.size() >= 1) chk("issue100", lg_pc[0], 32'h100);
        redirect(32'h40);
        cycle();
        chk("late_not_cached", {31'd0, bus.out_mem_ce}, 32'd1);

        // PC wrap: JAL +8 at the top of the address space lands at 4.
        redirect(32'hFFFFFFFC);
        clear_log();
        run_issues(2, 40);
        if (lg_pc.size() >= 2) begin
            chk("wrap_pc", lg_pc[0], 32'hFFFFFFFC);
            chk("wrap_jump", {31'd0, lg_j[0]}, 32'd1);
            chk("wrap_next", lg_pc[1], 32'h4);
        end

        max_lat = 3;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            bus.in_rob_full = ($urandom_range(0, 9) == 0);
            bus.in_rs_full  = ($urandom_range(0, 9) == 0);
            bus.in_slb_full = ($urandom_range(0, 9) == 0);
            bus.in_rob_misbranch = ($urandom_range(0, 39) == 0);
            bus.in_rob_newpc = ($urandom_range(0, 3) == 0)
                             ? (32'hFFFFFFE0 + (32'($urandom_range(0, 7)) << 2))
                             : (32'($urandom_range(0, 127)) << 2);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
